// File: rtl/vector_multiplier.sv
// vector_multiplier: LANES x BITS signed SIMD multiply, scaled by OUT_SHIFT; VECTOR_MULTIPLIER_SAT_EN builds the saturating clamp.
// Latency 2 cycles, 1 beat/cycle; in_ready drops only when both stages hold beats and out_ready is low.
module vector_multiplier #(
  parameter int BITS      = 8,
  parameter int LANES     = 4,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*BITS-1:0]   a,
  input  logic [LANES*BITS-1:0]   b,
  input  logic [1:0]              mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*BITS-1:0]   p,
  output logic [LANES-1:0]        p_ovf,
  input  logic                    clr_ovf,
  output logic [LANES-1:0]        ovf_sticky
);

  localparam int PW = 2 * BITS;
  localparam int W  = 2 * BITS + 1;
  localparam logic [W-1:0]        ONE   = W'(1);
  localparam logic [W-1:0]        RND   = (ONE << OUT_SHIFT) >> 1;
  localparam logic signed [W-1:0] S_MAX = (ONE << (BITS - 1)) - ONE;
  localparam logic signed [W-1:0] S_MIN = ~S_MAX;

  logic                    s1_valid_q, s2_valid_q;
  logic [LANES*PW-1:0]     prod_q, prod_d;
  logic [1:0]              mode_q;
  logic [LANES*BITS-1:0]   p_q, p_d;
  logic [LANES-1:0]        ovf_d, p_ovf_q, sticky_q, sticky_d;
  logic                    s1_en, s2_en;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en && !rst;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [PW-1:0] op_a, op_b;
    logic signed [W-1:0]  prod_x, r, s;
    logic [BITS-1:0]      res;

    assign op_a = {{BITS{a[i*BITS+BITS-1]}}, a[i*BITS +: BITS]};
    assign op_b = {{BITS{b[i*BITS+BITS-1]}}, b[i*BITS +: BITS]};
    assign prod_d[i*PW +: PW] = op_a * op_b;

    // One guard bit above the product keeps the rounding add from overflowing.
    assign prod_x = {prod_q[i*PW+PW-1], prod_q[i*PW +: PW]};
    assign r      = prod_x + (mode_q[0] ? RND : '0);
    assign s      = r >>> OUT_SHIFT;
    assign ovf_d[i] = (s > S_MAX) || (s < S_MIN);
`ifdef VECTOR_MULTIPLIER_SAT_EN
    assign res = (mode_q[1] && ovf_d[i])
               ? (s[W-1] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}})
               : s[BITS-1:0];
`else
    assign res = s[BITS-1:0];
`endif
    assign p_d[i*BITS +: BITS] = res;
  end

`ifndef VECTOR_MULTIPLIER_SAT_EN
  logic unused_sat;
  assign unused_sat = mode_q[1];
`endif

  // A set from a beat entering S2 takes priority over a simultaneous clear.
  assign sticky_d = (clr_ovf ? '0 : sticky_q) | ((s2_en && s1_valid_q) ? ovf_d : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      prod_q     <= '0;
      mode_q     <= '0;
      p_q        <= '0;
      p_ovf_q    <= '0;
      sticky_q   <= '0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= in_valid && in_ready;
        prod_q     <= prod_d;
        mode_q     <= mode;
      end
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
        p_q        <= p_d;
        p_ovf_q    <= s1_valid_q ? ovf_d : '0;
      end
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign p          = p_q;
  assign p_ovf      = p_ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_vector_multiplier.sv
// Self-checking bench for vector_multiplier (BITS=8, LANES=4, OUT_SHIFT=4): vector table, corner sequences, random stream.
module tb_vector_multiplier;
  localparam int BITS = 8;
  localparam int LANES = 4;
  localparam int OUT_SHIFT = 4;
`ifdef VECTOR_MULTIPLIER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic clr_ovf = 1'b0;
  logic [LANES*BITS-1:0] a = '0;
  logic [LANES*BITS-1:0] b = '0;
  logic [1:0] mode = '0;
  logic in_ready, out_valid;
  logic [LANES*BITS-1:0] p;
  logic [LANES-1:0] p_ovf, ovf_sticky;

  vector_multiplier #(.BITS(BITS), .LANES(LANES), .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .p_ovf(p_ovf), .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {BITS'(l3), BITS'(l2), BITS'(l1), BITS'(l0)};
  endfunction

  typedef struct {
    logic [LANES*BITS-1:0] p;
    logic [LANES-1:0]      ovf;
  } res_t;

  // Reference: exact integer product, optional half-LSB bias, floor division, range test, wrap or clamp.
  function automatic res_t model(input logic [LANES*BITS-1:0] va, input logic [LANES*BITS-1:0] vb,
                                 input logic [1:0] m);
    res_t r;
    longint pr, s, d, hi, lo, w, md;
    d  = 2 ** OUT_SHIFT;
    md = 2 ** BITS;
    hi = 2 ** (BITS - 1) - 1;
    lo = -hi - 1;
    r.p = '0;
    r.ovf = '0;
    for (int i = 0; i < LANES; i++) begin
      pr = longint'($signed(va[i*BITS +: BITS])) * longint'($signed(vb[i*BITS +: BITS]));
      if (m[0]) pr = pr + d / 2;
      s = (pr - (((pr % d) + d) % d)) / d;
      r.ovf[i] = (s > hi) || (s < lo);
      if (SAT && m[1] && r.ovf[i]) w = (s > 0) ? hi : lo;
      else w = s;
      w = ((w % md) + md) % md;
      r.p[i*BITS +: BITS] = BITS'(w);
    end
    return r;
  endfunction

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  res_t exp_q[$];
  res_t mon_e;
  logic mon_stall = 1'b0;
  logic [LANES*BITS-1:0] mon_p;
  logic [LANES-1:0] mon_ovf;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mon_stall = 1'b0;
    end else begin
      if (mon_stall) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_p", p, mon_p);
        chk("stall_hold_ovf", p_ovf, mon_ovf);
      end
      mon_stall = out_valid && !out_ready;
      mon_p = p;
      mon_ovf = p_ovf;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_p", p, mon_e.p);
          chk("sb_ovf", p_ovf, mon_e.ovf);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, mode));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] m);
    int k;
    a = va; b = vb; mode = m; in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("send_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mode;
    logic [31:0] ep;
    logic [3:0]  eovf;
  } vec_t;
  vec_t tbl [8];

  res_t ra, rb, rc;
  int lat, acc, cyc, gaps, nrdy, stale;
  logic took;

  initial begin
    tbl[0] = '{pk(3, -3, 100, 7), pk(3, 3, 1, 1), 2'b00, pk(0, -1, 6, 0), 4'b0000};
    tbl[1] = '{pk(3, -3, 100, 7), pk(3, 3, 1, 1), 2'b01, pk(1, -1, 6, 0), 4'b0000};
    tbl[2] = '{pk(100, -128, -128, 127), pk(100, -128, 127, 127), 2'b00, pk(113, 0, 8, -16), 4'b1111};
    tbl[3] = '{pk(-8, 8, -24, 24), pk(1, 1, 1, 1), 2'b01, pk(0, 1, -1, 2), 4'b0000};
    tbl[4] = '{pk(-8, 8, -24, 24), pk(1, 1, 1, 1), 2'b00, pk(-1, 0, -2, 1), 4'b0000};
`ifdef VECTOR_MULTIPLIER_SAT_EN
    tbl[5] = '{pk(100, -128, -128, 127), pk(100, -128, 127, 127), 2'b10, pk(127, 127, -128, 127), 4'b1111};
    tbl[6] = '{pk(23, 32, -32, -43), pk(89, 64, 64, 48), 2'b10, pk(127, 127, -128, -128), 4'b1010};
    tbl[7] = '{pk(100, -128, -128, 127), pk(100, -128, 127, 127), 2'b11, pk(127, 127, -128, 127), 4'b1111};
`else
    tbl[5] = '{pk(100, -128, -128, 127), pk(100, -128, 127, 127), 2'b10, pk(113, 0, 8, -16), 4'b1111};
    tbl[6] = '{pk(23, 32, -32, -43), pk(89, 64, 64, 48), 2'b10, pk(127, -128, -128, 127), 4'b1010};
    tbl[7] = '{pk(100, -128, -128, 127), pk(100, -128, 127, 127), 2'b11, pk(113, 0, 8, -16), 4'b1111};
`endif

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_p", p, 0);
    chk("rst_p_ovf", p_ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // Directed vectors, one beat at a time
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1 clr_ovf = 1'b1;
      @(posedge clk); #1 clr_ovf = 1'b0;
      send(tbl[t].a, tbl[t].b, tbl[t].mode);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", t), lat, 2);
      chk($sformatf("vec%0d_p", t), p, tbl[t].ep);
      chk($sformatf("vec%0d_p_ovf", t), p_ovf, tbl[t].eovf);
      chk($sformatf("vec%0d_sticky", t), ovf_sticky, tbl[t].eovf);
    end

    // Backpressure: two beats fill the pipe, third waits for out_ready
    ra = model(pk(5, -7, 90, 1), pk(20, 30, -3, 1), 2'b01);
    rb = model(pk(127, 2, -50, 60), pk(-128, 3, 50, 60), 2'b00);
    rc = model(pk(-1, 4, 9, -100), pk(1, 64, 9, 3), 2'b11);
    @(posedge clk); #1;
    out_ready = 1'b0;
    a = pk(5, -7, 90, 1); b = pk(20, 30, -3, 1); mode = 2'b01; in_valid = 1'b1;
    @(negedge clk); chk("bp_ready_a", in_ready, 1);
    @(posedge clk); #1;
    a = pk(127, 2, -50, 60); b = pk(-128, 3, 50, 60); mode = 2'b00;
    @(negedge clk); chk("bp_ready_b", in_ready, 1);
    @(posedge clk); #1;
    a = pk(-1, 4, 9, -100); b = pk(1, 64, 9, 3); mode = 2'b11;
    @(negedge clk);
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_valid", out_valid, 1);
    chk("bp_full_p", p, ra.p);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_still_ready", in_ready, 0);
    chk("bp_still_p", p, ra.p);
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1 chk("bp_ready_rise", in_ready, 1);
    @(negedge clk); chk("bp_out_a_valid", out_valid, 1); chk("bp_out_a", p, ra.p);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("bp_out_b_valid", out_valid, 1); chk("bp_out_b", p, rb.p);
    @(negedge clk); chk("bp_out_c_valid", out_valid, 1); chk("bp_out_c", p, rc.p);
    @(negedge clk); chk("bp_empty", out_valid, 0);

    // Sticky: clear coincides with an overflowing beat entering S2
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk); chk("sticky_cleared", ovf_sticky, 0);
    @(posedge clk); #1;
    a = pk(100, -128, -128, 127); b = pk(100, -128, 127, 127); mode = 2'b00; in_valid = 1'b1;
    @(negedge clk); chk("sticky_accept", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0; clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk);
    chk("sticky_set_wins", ovf_sticky, 4'b1111);
    chk("sticky_beat_valid", out_valid, 1);
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk); chk("sticky_lone_clear", ovf_sticky, 0);

    // Random stream with toggled valid and ready
    acc = 0; cyc = 0; took = 1'b0;
    while (acc < 100 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (took) in_valid = 1'b0;
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        a = $urandom; b = $urandom; mode = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_accepted", acc, 100);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    chk("stream_drained", exp_q.size(), 0);

    // Back-to-back with both sides open: no bubbles
    gaps = 0; nrdy = 0;
    for (int j = 0; j < 23; j++) begin
      @(posedge clk); #1;
      if (j < 20) begin
        in_valid = 1'b1;
        a = $urandom; b = $urandom; mode = 2'($urandom_range(0, 3));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (j < 20 && !in_ready) nrdy++;
      if (j >= 2 && j <= 21 && !out_valid) gaps++;
    end
    chk("stream_not_ready", nrdy, 0);
    chk("stream_gaps", gaps, 0);

    // Reset with two beats in flight
    @(posedge clk); #1;
    out_ready = 1'b0; clr_ovf = 1'b0;
    a = pk(100, -128, -128, 127); b = pk(100, -128, 127, 127); mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    a = pk(9, 9, 9, 9); b = pk(9, 9, 9, 9);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("inflight_valid", out_valid, 1);
    chk("inflight_sticky", ovf_sticky, 4'b1111);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_p", p, 0);
    chk("midrst_p_ovf", p_ovf, 0);
    chk("midrst_sticky", ovf_sticky, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("postrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("postrst_no_stale", stale, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
